// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per clock.
// start/busy/done handshake; sum/cout/ovf are registered and held until the next completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_adder: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb, res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, cnt_last;
    logic             h1_s, h1_c, h2_c, s, c;

    // Full adder as two half-adder stages on the current LSBs
    assign h1_s     = ra[0] ^ rb[0];
    assign h1_c     = ra[0] & rb[0];
    assign s        = h1_s ^ carry;
    assign h2_c     = h1_s & carry;
    assign c        = h1_c | h2_c;
    assign cnt_last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            // Subtraction as a + ~b + 1, the +1 entering as the initial carry
            ra    <= a;
            rb    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            ra    <= ra >> 1;
            rb    <= rb >> 1;
            res   <= {s, res[WIDTH-1:1]};
            carry <= c;
            cnt   <= cnt + CW'(1);
            if (cnt_last) begin
                // carry still holds the carry into the MSB here
                sum  <= {s, res[WIDTH-1:1]};
                cout <= c;
                ovf  <= carry ^ c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 2, 8, 16 and 32,
// with expected results queued at issue time and compared at completion.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a_bus = '0, b_bus = '0;
    logic        st8 = 1'b0, st16 = 1'b0, str = 1'b0;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
    logic        busy2, done2, cout2, ovf2;
    logic [1:0]  sum2;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;

    int checks = 0;
    int errs   = 0;
    logic [33:0] q8[$], q2[$], q32[$];   // {ovf, cout, sum}

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .sub(sub), .a(a_bus[7:0]), .b(b_bus[7:0]),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));
    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .sub(sub), .a(a_bus[15:0]), .b(b_bus[15:0]),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));
    serial_adder #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(str), .sub(sub), .a(a_bus[1:0]), .b(b_bus[1:0]),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));
    serial_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(str), .sub(sub), .a(a_bus), .b(b_bus),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32));

    // Behavioural reference: wide integer add, signed overflow from operand/result signs
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [63:0] m, aa, bb, f;
        logic        o;
        m  = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & m;
        bb = s ? (~{32'd0, b} & m) : ({32'd0, b} & m);
        f  = aa + bb + {63'd0, s};
        o  = (aa[w-1] == bb[w-1]) && (f[w-1] != aa[w-1]);
        return {o, f[w], f[31:0] & m[31:0]};
    endfunction

    function automatic logic [33:0] ex(input logic [31:0] s, input logic c, input logic o);
        return {o, c, s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic dn(input int w);
        case (w)
            8:  return done8;
            16: return done16;
            default: return done32;
        endcase
    endfunction

    function automatic logic bz(input int w);
        case (w)
            8:  return busy8;
            16: return busy16;
            default: return busy32;
        endcase
    endfunction

    // lat = edges from the accepting edge to done; bc = busy samples seen meanwhile
    task automatic wait_done(input int w, output int lat, output int bc);
        lat = -1;
        bc  = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (dn(w)) begin
                lat = n - 1;
                return;
            end
            if (bz(w)) bc++;
        end
        checks++;
        errs++;
        $error("FAIL timeout_w%0d: observed no done, expected done within 100 cycles", w);
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [33:0] e);
        @(negedge clk);
        a_bus = {24'd0, a};
        b_bus = {24'd0, b};
        sub   = s;
        st8   = 1'b1;
        q8.push_back(e);
        @(posedge clk);
        #1 st8 = 1'b0;
    endtask

    task automatic check8(input string tag);
        logic [33:0] e;
        if (q8.size() == 0) begin
            checks++;
            errs++;
            $error("FAIL %s: observed empty scoreboard, expected a pending result", tag);
            return;
        end
        e = q8.pop_front();
        chk(tag, {30'd0, ovf8, cout8, 24'd0, sum8}, {30'd0, e[33], e[32], 24'd0, e[7:0]});
    endtask

    initial begin
        int lat, bc;
        logic [33:0] e;

        // Reset state
        #1;
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_done", {63'd0, done8}, 64'd0);
        chk("rst_res",  {54'd0, ovf8, cout8, sum8}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic add with latency and busy length
        go8(8'h3C, 8'h42, 1'b0, ex(32'h7E, 1'b0, 1'b0));
        wait_done(8, lat, bc);
        chk("add_latency", 64'(lat), 64'd8);
        chk("add_busy_cycles", 64'(bc), 64'd8);
        check8("add_3c_42");
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done8}, 64'd0);

        go8(8'hFF, 8'h01, 1'b0, ex(32'h00, 1'b1, 1'b0)); wait_done(8, lat, bc); check8("add_ff_01");
        go8(8'h7F, 8'h01, 1'b0, ex(32'h80, 1'b0, 1'b1)); wait_done(8, lat, bc); check8("add_7f_01");
        go8(8'h05, 8'h07, 1'b1, ex(32'hFE, 1'b0, 1'b0)); wait_done(8, lat, bc); check8("sub_05_07");
        go8(8'h80, 8'h01, 1'b1, ex(32'h7F, 1'b1, 1'b1)); wait_done(8, lat, bc); check8("sub_80_01");
        go8(8'h10, 8'h10, 1'b1, ex(32'h00, 1'b1, 1'b0)); wait_done(8, lat, bc); check8("sub_10_10");

        // start during RUN is ignored and not queued
        go8(8'h12, 8'h34, 1'b0, ex(32'h46, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        a_bus = 32'hFF; b_bus = 32'hFF; sub = 1'b1; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        wait_done(8, lat, bc);
        check8("start_mid_run");
        @(negedge clk);
        chk("no_queued_op", {62'd0, busy8, done8}, 64'd0);

        // Back-to-back: start in the DONE cycle
        go8(8'h20, 8'h30, 1'b0, ex(32'h50, 1'b0, 1'b0));
        wait_done(8, lat, bc);
        check8("b2b_first");
        a_bus = 32'h01; b_bus = 32'h02; sub = 1'b0; st8 = 1'b1;
        q8.push_back(ex(32'h03, 1'b0, 1'b0));
        @(posedge clk);
        #1 st8 = 1'b0;
        @(negedge clk);
        chk("b2b_no_gap_busy", {63'd0, busy8}, 64'd1);
        chk("b2b_sum_held", {56'd0, sum8}, 64'h50);
        wait_done(8, lat, bc);
        check8("b2b_second");

        // Reset mid-RUN aborts the operation
        go8(8'h11, 8'h22, 1'b0, ex(32'h33, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {52'd0, busy8, done8, ovf8, cout8, sum8}, 64'd0);
        e = q8.pop_back();
        repeat (3) @(negedge clk);
        chk("abort_no_done", {62'd0, busy8, done8}, 64'd0);
        rst_n = 1'b1;
        go8(8'hA5, 8'h5A, 1'b0, ex(32'hFF, 1'b0, 1'b0));
        wait_done(8, lat, bc);
        check8("after_reset");

        // WIDTH=16 carry through all bits
        @(negedge clk);
        a_bus = 32'hFFFF; b_bus = 32'h0001; sub = 1'b0; st16 = 1'b1;
        @(posedge clk);
        #1 st16 = 1'b0;
        wait_done(16, lat, bc);
        chk("w16_latency", 64'(lat), 64'd16);
        chk("w16_result", {47'd0, cout16, sum16}, 64'h10000);

        // Random regression at WIDTH 2, 8 and 32 started together
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a_bus = $urandom;
            b_bus = $urandom;
            sub   = 1'($urandom_range(0, 1));
            st8   = 1'b1;
            str   = 1'b1;
            q2.push_back(model(2, a_bus, b_bus, sub));
            q8.push_back(model(8, a_bus, b_bus, sub));
            q32.push_back(model(32, a_bus, b_bus, sub));
            @(posedge clk);
            #1 st8 = 1'b0; str = 1'b0;
            wait_done(32, lat, bc);
            e = q2.pop_front();
            chk("rand_w2", {28'd0, ovf2, cout2, 30'd0, sum2}, {28'd0, e[33], e[32], 30'd0, e[1:0]});
            check8("rand_w8");
            e = q32.pop_front();
            chk("rand_w32", {28'd0, ovf32, cout32, sum32}, {30'd0, e});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor. Processes one bit per clock, LSB first, through a single full-adder cell built from two half-adder stages.
- Used in the vending datapath for credit and change arithmetic, where area matters more than latency.
- Uses a start/busy/done handshake. Results are registered and held until the next operation is accepted.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is 2 to 32.
- CW, $clog2(WIDTH+1), bit-counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when the result is updated.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  add: carry out; sub: no-borrow (1 when a >= b, unsigned).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE immediately.
  - busy, done, sum, cout, ovf, the internal shift registers, carry and counter all clear to 0.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - Edge with start=1: capture ra <= a, rb <= (sub ? ~b : b), carry <= sub, cnt <= 0, then go to RUN.
  - Operands are captured on the accepting edge only. Later changes on a/b/sub have no effect.
- RUN:
  - busy=1.
  - Each edge computes s = ra[0]^rb[0]^carry and c = (ra[0]&rb[0]) | (carry&(ra[0]^rb[0])).
  - The result shift register shifts s in at the MSB. ra and rb shift right; carry <= c; cnt <= cnt+1.
  - On the edge where cnt == WIDTH-1, record carry-in to the MSB (old carry) as cmsb and final carry as c.
  - That same edge transfers to the outputs: sum <= completed result, cout <= c, ovf <= cmsb ^ c.
  - The FSM then goes to DONE.
  - start is ignored throughout RUN; no queuing.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - start=1 on this edge is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency:
  - Start accepted on edge E0; busy high from E0 through EWIDTH.
  - sum/cout/ovf update and done rises at edge EWIDTH; done falls at EWIDTH+1.
  - Throughput is one result per WIDTH+1 cycles.
- Output hold:
  - sum/cout/ovf change only at the completion edge or on reset.
  - They hold their last result through IDLE and through the next RUN.
- Width rules:
  - sum is a modulo-2^WIDTH result.
  - Subtraction is a + ~b + 1, with the +1 supplied as the initial carry.
  - WIDTH outside 2..32 is a configuration error; use a generate-time check.

Test Plan:
- WIDTH=8, add a=0x3C, b=0x42 -> done exactly 8 cycles after the accepting edge; sum=0x7E, cout=0, ovf=0; busy high for 8 cycles.
- Add boundaries:
  - 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
  - 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
- Subtract:
  - 0x05-0x07 -> sum=0xFE, cout=0, ovf=0.
  - 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
  - 0x10-0x10 -> sum=0x00, cout=1.
- Handshake:
  - Pulse start again mid-RUN with different operands -> ignored; original result returned.
  - Assert start in the DONE cycle -> new op accepted with no IDLE gap; previous sum held until the second done.
- Reset: drop rst_n at cycle 4 of a RUN -> all outputs 0 immediately, no done pulse; a fresh op after release completes correctly.
- WIDTH=16 build: 0xFFFF+0x0001 -> sum=0x0000, cout=1, done after 16 cycles. Random regression of 1000 ops against a behavioural model for WIDTH=2, 8 and 32.
